// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-requester command bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT1 = 2'd1,
        GRANT2 = 2'd2
    } state_t;

    typedef enum logic {
        OWN1 = 1'b0,
        OWN2 = 1'b1
    } owner_t;

    typedef struct packed {
        logic       cmd;
        logic [7:0] addr;
        logic [7:0] data;
    } bus_txn_t;

    localparam logic CMD_W = 1'b1;
    localparam logic CMD_R = 1'b0;

    localparam int CNT_W = 4;

    function automatic state_t grant_of(input owner_t owner);
        return (owner == OWN1) ? GRANT1 : GRANT2;
    endfunction

endpackage

// File: rtl/bus_arb_rd_track.sv
// Tracks which requester issued each read and steers the returning slave data
// back to it, one cycle after the slave presents it.
module bus_arb_rd_track
    import bus_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       rd_push,
    input  owner_t     rd_owner,
    input  logic [7:0] bus_rdata,
    output logic       req1_rvalid,
    output logic [7:0] req1_rdata,
    output logic       req2_rvalid,
    output logic [7:0] req2_rdata
);

    // Stage 0 lines up with the bus strobe, stage 1 with the slave data.
    logic [1:0] tag_vld_q;
    owner_t     tag_own_q [2];
    logic       ret1;
    logic       ret2;

    assign ret1 = tag_vld_q[1] && (tag_own_q[1] == OWN1);
    assign ret2 = tag_vld_q[1] && (tag_own_q[1] == OWN2);

    always_ff @(posedge clk) begin
        // NOTE: the whole tag pipe is reset, not just the valid bits, so reads
        // in flight at reset are dropped and no X owner can leak out.
        if (reset) begin
            tag_vld_q    <= '0;
            tag_own_q[0] <= OWN1;
            tag_own_q[1] <= OWN1;
            req1_rvalid  <= 1'b0;
            req2_rvalid  <= 1'b0;
            req1_rdata   <= '0;
            req2_rdata   <= '0;
        end else begin
            tag_vld_q    <= {tag_vld_q[0], rd_push};
            tag_own_q[0] <= rd_owner;
            tag_own_q[1] <= tag_own_q[0];
            req1_rvalid  <= ret1;
            req2_rvalid  <= ret2;
            if (ret1) req1_rdata <= bus_rdata;
            if (ret2) req2_rdata <= bus_rdata;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one registered command bus
// between two valid/ready requesters; read data is routed back by owner tag.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req1_valid,
    input  logic       req1_cmd,
    input  logic [7:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       req1_rvalid,
    output logic [7:0] req1_rdata,
    input  logic       req2_valid,
    input  logic       req2_cmd,
    input  logic [7:0] req2_addr,
    input  logic [7:0] req2_data,
    output logic       req2_ready,
    output logic       req2_rvalid,
    output logic [7:0] req2_rdata,
    output logic       bus_valid,
    output logic       bus_cmd,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_data,
    input  logic [7:0] bus_rdata,
    output logic [1:0] gnt
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    state_t            state_q;
    state_t            state_d;
    owner_t            last_q;
    logic [CNT_W-1:0]  burst_q;
    logic [CNT_W-1:0]  burst_inc;
    logic              xfer1;
    logic              xfer2;
    logic              xfer;
    bus_txn_t          sel_txn;
    bus_txn_t          bus_q;
    logic              bus_valid_q;
    logic              rd_push;
    owner_t            rd_owner;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case below can leave one unassigned and infer a latch.
        state_d    = state_q;
        req1_ready = (state_q == GRANT1);
        req2_ready = (state_q == GRANT2);
        gnt        = {state_q == GRANT2, state_q == GRANT1};
        xfer1      = req1_valid && req1_ready;
        xfer2      = req2_valid && req2_ready;
        xfer       = xfer1 || xfer2;
        burst_inc  = (burst_q == MAX_CNT) ? burst_q : burst_q + CNT_W'(1);
        sel_txn    = xfer2 ? '{cmd: req2_cmd, addr: req2_addr, data: req2_data}
                           : '{cmd: req1_cmd, addr: req1_addr, data: req1_data};
        rd_push    = xfer && (sel_txn.cmd == CMD_R);
        rd_owner   = xfer2 ? OWN2 : OWN1;

        unique case (state_q)
            IDLE: begin
                if (req1_valid && req2_valid)
                    state_d = grant_of((last_q == OWN1) ? OWN2 : OWN1);
                else if (req1_valid)
                    state_d = GRANT1;
                else if (req2_valid)
                    state_d = GRANT2;
            end
            GRANT1: begin
                if (!req1_valid)
                    state_d = req2_valid ? GRANT2 : IDLE;
                else if (burst_inc == MAX_CNT && req2_valid)
                    state_d = GRANT2;
            end
            GRANT2: begin
                if (!req2_valid)
                    state_d = req1_valid ? GRANT1 : IDLE;
                else if (burst_inc == MAX_CNT && req1_valid)
                    state_d = GRANT1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= OWN2;
            burst_q     <= '0;
            bus_valid_q <= 1'b0;
            bus_q       <= '0;
        end else begin
            state_q     <= state_d;
            bus_valid_q <= xfer;
            if (xfer) bus_q <= sel_txn;

            // The burst count belongs to the current tenure; any state change starts a new one.
            if (state_d != state_q) begin
                burst_q <= '0;
                if (state_d == GRANT1) last_q <= OWN1;
                else if (state_d == GRANT2) last_q <= OWN2;
            end else if (xfer) begin
                burst_q <= burst_inc;
            end
        end
    end

    assign bus_valid = bus_valid_q;
    assign bus_cmd   = bus_q.cmd;
    assign bus_addr  = bus_q.addr;
    assign bus_data  = bus_q.data;

    bus_arb_rd_track u_rd_track (
        .clk         (clk),
        .reset       (reset),
        .rd_push     (rd_push),
        .rd_owner    (rd_owner),
        .bus_rdata   (bus_rdata),
        .req1_rvalid (req1_rvalid),
        .req1_rdata  (req1_rdata),
        .req2_rvalid (req2_rvalid),
        .req2_rdata  (req2_rdata)
    );

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed requester streams, hand-ordered
// expected bus transfers and read returns, checked by an independent monitor.
module tb_bus_arbiter;
    import bus_arb_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req1_valid = 1'b0, req1_cmd = 1'b0;
    logic [7:0] req1_addr = '0, req1_data = '0;
    logic       req1_ready, req1_rvalid;
    logic [7:0] req1_rdata;
    logic       req2_valid = 1'b0, req2_cmd = 1'b0;
    logic [7:0] req2_addr = '0, req2_data = '0;
    logic       req2_ready, req2_rvalid;
    logic [7:0] req2_rdata;
    logic       bus_valid, bus_cmd;
    logic [7:0] bus_addr, bus_data;
    logic [7:0] bus_rdata = '0;
    logic [1:0] gnt;

    bus_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_addr(req1_addr), .req1_data(req1_data),
        .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .req2_valid(req2_valid), .req2_cmd(req2_cmd), .req2_addr(req2_addr), .req2_data(req2_data),
        .req2_ready(req2_ready), .req2_rvalid(req2_rvalid), .req2_rdata(req2_rdata),
        .bus_valid(bus_valid), .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_data(bus_data),
        .bus_rdata(bus_rdata), .gnt(gnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cmd;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] rdata;
        bit         chk_rd;
    } vec_t;

    typedef struct {
        int         req;
        logic [7:0] data;
        int         cyc;
    } rd_exp_t;

    vec_t     vq1[$];
    vec_t     vq2[$];
    bus_txn_t exp_bus[$];
    rd_exp_t  exp_rd[$];
    int       hs_log[$];
    int       strobe_log[$];
    int       first_hs[3];
    int       last_hs[3];
    int       cyc = 0;
    int       n_checks = 0;
    int       n_pass = 0;

    bus_txn_t   mon_b;
    rd_exp_t    mon_r;
    logic       sl_hit;
    logic [7:0] sl_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic add(input int r, input logic cmd, input logic [7:0] addr, input logic [7:0] data,
                       input logic [7:0] rdata, input bit chk_rd);
        vec_t v;
        v = '{cmd, addr, data, rdata, chk_rd};
        if (r == 1) vq1.push_back(v);
        else vq2.push_back(v);
    endtask

    task automatic expb(input logic cmd, input logic [7:0] addr, input logic [7:0] data);
        exp_bus.push_back('{cmd: cmd, addr: addr, data: data});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check(name, {req1_ready, req1_rvalid, req1_rdata, req2_ready, req2_rvalid, req2_rdata,
                     bus_valid, bus_cmd, bus_addr, bus_data, gnt}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Drives one requester's queued vectors back to back, holding valid until ready.
    task automatic run_req(input int r);
        vec_t v;
        int   t;
        logic rdy;
        bit   first = 1'b1;
        while ((r == 1 ? vq1.size() : vq2.size()) > 0) begin
            if (r == 1) begin
                v = vq1.pop_front();
                req1_valid = 1'b1; req1_cmd = v.cmd; req1_addr = v.addr; req1_data = v.data;
            end else begin
                v = vq2.pop_front();
                req2_valid = 1'b1; req2_cmd = v.cmd; req2_addr = v.addr; req2_data = v.data;
            end
            t = 0;
            do begin
                @(negedge clk);
                rdy = (r == 1) ? req1_ready : req2_ready;
                t++;
            end while (!rdy && t < 64);
            if (!rdy) begin
                check($sformatf("req%0d_ready_timeout", r), rdy, 1);
            end else begin
                hs_log.push_back(cyc);
                if (first) first_hs[r] = cyc;
                first = 1'b0;
                last_hs[r] = cyc;
                if (v.chk_rd) exp_rd.push_back('{r, v.rdata, cyc + 3});
            end
            @(posedge clk); #1;
        end
        if (r == 1) req1_valid = 1'b0;
        else req2_valid = 1'b0;
    endtask

    task automatic sample_gnt(input int n, input logic [23:0] exp_seq);
        logic [23:0] seq = '0;
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (gnt == 2'b00 && t < 20);
        for (int i = 0; i < n; i++) begin
            seq = {seq[21:0], gnt};
            if (i < n - 1) @(negedge clk);
        end
        check("t2_gnt_seq", seq, exp_seq);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Slave: read data one cycle after the strobe, addr ^ 8'h7A.
    initial forever begin
        @(negedge clk);
        sl_hit  = bus_valid && (bus_cmd == CMD_R);
        sl_addr = bus_addr;
        @(posedge clk); #1;
        bus_rdata = sl_hit ? (sl_addr ^ 8'h7A) : 8'h00;
    end

    // Monitor: pops expectations whenever the DUT presents a bus strobe or read return.
    initial forever begin
        @(negedge clk);
        if (bus_valid) begin
            strobe_log.push_back(cyc);
            if (exp_bus.size() == 0) begin
                check("bus_unexpected_strobe", bus_valid, 1'b0);
            end else begin
                mon_b = exp_bus.pop_front();
                check("bus_cmd", bus_cmd, mon_b.cmd);
                check("bus_addr", bus_addr, mon_b.addr);
                check("bus_data", bus_data, mon_b.data);
            end
            if (hs_log.size() == 0) check("bus_no_handshake", bus_valid, 1'b0);
            else check("bus_latency", cyc, hs_log.pop_front() + 1);
        end
        if (req1_rvalid || req2_rvalid) begin
            if (exp_rd.size() == 0) begin
                check("rd_unexpected", {req1_rvalid, req2_rvalid}, 2'b00);
            end else begin
                mon_r = exp_rd.pop_front();
                check("rd_owner", {req1_rvalid, req2_rvalid}, (mon_r.req == 1) ? 2'b10 : 2'b01);
                check("rd_data", (mon_r.req == 1) ? req1_rdata : req2_rdata, mon_r.data);
                check("rd_cycle", cyc, mon_r.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset("reset_outs");

        // Single write: ready one cycle after valid, strobe one cycle later.
        add(1, CMD_W, 8'h10, 8'hA5, 8'h00, 1'b0);
        expb(CMD_W, 8'h10, 8'hA5);
        fork
            run_req(1);
            begin
                @(negedge clk); check("t1_ready_early", req1_ready, 1'b0);
                @(negedge clk); check("t1_ready", req1_ready, 1'b1);
                                check("t1_gnt", gnt, 2'b01);
                @(negedge clk); check("t1_bus_valid", bus_valid, 1'b1);
                                check("t1_gnt_bus", gnt, 2'b01);
            end
        join
        idle(4);

        // Contention from reset: 4x req1, 4x req2, 4x req1 with no bus gap.
        do_reset("t2_reset_outs");
        for (int i = 0; i < 8; i++) add(1, CMD_W, 8'(8'h10 + i), 8'(8'hB0 + i), 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) add(2, CMD_W, 8'(8'h20 + i), 8'(8'hC0 + i), 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) expb(CMD_W, 8'(8'h10 + i), 8'(8'hB0 + i));
        for (int i = 0; i < 4; i++) expb(CMD_W, 8'(8'h20 + i), 8'(8'hC0 + i));
        for (int i = 4; i < 8; i++) expb(CMD_W, 8'(8'h10 + i), 8'(8'hB0 + i));
        strobe_log.delete();
        fork
            run_req(1);
            run_req(2);
            sample_gnt(12, 24'h55AA55);
        join
        idle(3);
        check("t2_strobes", strobe_log.size(), 12);
        check("t2_contig", strobe_log[$] - strobe_log[0], 11);

        // req2 read returns to req2 only, three cycles after the handshake.
        add(2, CMD_R, 8'h20, 8'h00, 8'h5A, 1'b1);
        expb(CMD_R, 8'h20, 8'h00);
        run_req(2);
        idle(5);
        check("t3_rd_done", exp_rd.size(), 0);

        // req1 alone, 10 back-to-back writes: no grant loss at the burst limit.
        for (int i = 0; i < 10; i++) begin
            add(1, CMD_W, 8'(8'h30 + i), 8'(8'hD0 + i), 8'h00, 1'b0);
            expb(CMD_W, 8'(8'h30 + i), 8'(8'hD0 + i));
        end
        strobe_log.delete();
        run_req(1);
        idle(3);
        check("t4_strobes", strobe_log.size(), 10);
        check("t4_contig", strobe_log[$] - strobe_log[0], 9);

        // Back-to-back reads, then a write overlapping the read returns.
        add(1, CMD_R, 8'h40, 8'h00, 8'h3A, 1'b1); expb(CMD_R, 8'h40, 8'h00);
        add(1, CMD_R, 8'h41, 8'h00, 8'h3B, 1'b1); expb(CMD_R, 8'h41, 8'h00);
        add(1, CMD_R, 8'h42, 8'h00, 8'h38, 1'b1); expb(CMD_R, 8'h42, 8'h00);
        add(1, CMD_W, 8'h43, 8'hE3, 8'h00, 1'b0); expb(CMD_W, 8'h43, 8'hE3);
        run_req(1);
        idle(6);
        check("t4b_rd_done", exp_rd.size(), 0);

        // req1 drops after 2 transfers while req2 waits: switch next cycle, fresh burst.
        do_reset("t5_reset_outs");
        add(1, CMD_W, 8'h50, 8'h11, 8'h00, 1'b0); expb(CMD_W, 8'h50, 8'h11);
        add(1, CMD_W, 8'h51, 8'h12, 8'h00, 1'b0); expb(CMD_W, 8'h51, 8'h12);
        for (int i = 0; i < 4; i++) begin
            add(2, CMD_W, 8'(8'h60 + i), 8'(8'h20 + i), 8'h00, 1'b0);
            expb(CMD_W, 8'(8'h60 + i), 8'(8'h20 + i));
        end
        fork
            run_req(1);
            run_req(2);
        join
        idle(3);
        check("t5_switch", first_hs[2], last_hs[1] + 2);
        check("t5_burst", last_hs[2] - first_hs[2], 3);

        // Reset one cycle after a read strobe: the read never returns.
        add(1, CMD_R, 8'h70, 8'h00, 8'h00, 1'b0);
        expb(CMD_R, 8'h70, 8'h00);
        run_req(1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_reset_outs", {req1_ready, req1_rvalid, req1_rdata, req2_ready, req2_rvalid, req2_rdata,
                                bus_valid, bus_cmd, bus_addr, bus_data, gnt}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(6);

        // First tie after reset goes to req1.
        add(1, CMD_W, 8'h80, 8'hC1, 8'h00, 1'b0); expb(CMD_W, 8'h80, 8'hC1);
        add(2, CMD_W, 8'h90, 8'hC2, 8'h00, 1'b0); expb(CMD_W, 8'h90, 8'hC2);
        fork
            run_req(1);
            run_req(2);
            begin
                @(negedge clk); check("t6_tie_idle", gnt, 2'b00);
                @(negedge clk); check("t6_tie_gnt", gnt, 2'b01);
            end
        join
        idle(6);

        check("end_bus_queue", exp_bus.size(), 0);
        check("end_rd_queue", exp_rd.size(), 0);
        check("end_hs_log", hs_log.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
